even_div_mon: RTL

EVEN_DIV_MON -- requirements
Module: even_div_mon

---
 rtl/even_div_pkg.sv | 15 +
 rtl/even_div_mon_chan.sv | 100 ++++++++++
 rtl/even_div_mon.sv | 75 +++++++
 3 files changed

// File: rtl/even_div_pkg.sv
// Shared types and constants for the even-divider output monitor.
package even_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned ERR_CNT_W = 8;

  // Expected divide ratio per channel: clk_out2, clk_out4, clk_out8.
  localparam int unsigned DIV_TAB [NUM_CH] = '{2, 4, 8};

endpackage

// File: rtl/even_div_mon_chan.sv
// One monitored divider output: checks every half-period against DIV/2 and
// tracks lock, raising a one-cycle err pulse on a bad run or a stall.
module even_div_mon_chan
  import even_div_pkg::*;
#(
  parameter int unsigned DIV      = 2,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic trans_i,
  output logic lock_o,
  output logic err_o
);

  localparam int unsigned H      = DIV / 2;
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  chan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic [CNT_W-1:0]  run_len_c;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      run_q   <= '0;
      good_q  <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      good_q  <= good_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  // run_len_c counts the current cycle, so a transition here closes a run of run_len_c cycles.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    good_d    = good_q;
    lock_d    = (good_q == GOOD_W'(LOCK_CNT));
    err_d     = 1'b0;
    run_len_c = run_q + CNT_W'(1);

    if (!enable_i) begin
      state_d = IDLE;
      run_d   = '0;
      good_d  = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          run_d = '0;
          if (trans_i) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (trans_i) begin
            run_d = '0;
            if (run_len_c == CNT_W'(H)) begin
              if (good_q != GOOD_W'(LOCK_CNT)) begin
                good_d = good_q + GOOD_W'(1);
              end
            end else begin
              err_d  = 1'b1;
              lock_d = 1'b0;
              good_d = '0;
            end
          end else if (run_len_c == CNT_W'(H + 1)) begin
            // Stalled output: drop back and wait for a fresh edge.
            state_d = IDLE;
            run_d   = '0;
            err_d   = 1'b1;
            lock_d  = 1'b0;
            good_d  = '0;
          end else begin
            run_d = run_len_c;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  assign lock_o = lock_q;
  assign err_o  = err_q;

endmodule

// File: rtl/even_div_mon.sv
// Lock/error monitor for the /2, /4, /8 outputs of an even clock divider.
// Optional per-channel saturating error counters: define EVEN_DIV_MON_ERRCNT_EN.
module even_div_mon
  import even_div_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             div_in,
  output logic [NUM_CH-1:0]             lock,
  output logic [NUM_CH-1:0]             err,
  output logic [NUM_CH*ERR_CNT_W-1:0]   err_cnt
);

  logic [NUM_CH-1:0] s1_q, s2_q;
  logic [NUM_CH-1:0] trans_c;

  // Two-stage capture; a transition is a difference between the stages.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= div_in;
      s2_q <= s1_q;
    end
  end

  assign trans_c = s1_q ^ s2_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    even_div_mon_chan #(
      .DIV      (DIV_TAB[g]),
      .LOCK_CNT (LOCK_CNT),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk_i    (clk_in),
      .rst_i    (rst),
      .enable_i (enable),
      .trans_i  (trans_c[g]),
      .lock_o   (lock[g]),
      .err_o    (err[g])
    );
  end

`ifdef EVEN_DIV_MON_ERRCNT_EN
  logic [NUM_CH-1:0][ERR_CNT_W-1:0] cnt_q, cnt_d;

  // Counts survive enable toggling; only rst clears them.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (err[i] && (cnt_q[i] != {ERR_CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
